// File: rtl/memcopy_pkg.sv
// Shared types and constants for the MEMCOPY multi-cycle sequencer.
package memcopy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mc_state_t;

    localparam logic [6:0]  OPC_MEMCOPY = 7'b1111111;
    localparam logic [6:0]  OPC_UMUL    = 7'b0111111;
    localparam int unsigned WORD_BYTES  = 4;

endpackage

// File: rtl/memcopy_sequencer_mem_port_mux.sv
// 2:1 data-memory port selector: core load/store path vs. copy engine.
module mem_port_mux #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  sel_i,
    input  logic                  core_read_i,
    input  logic                  core_write_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    input  logic                  copy_read_i,
    input  logic                  copy_write_i,
    input  logic [ADDR_WIDTH-1:0] copy_addr_i,
    input  logic [DATA_WIDTH-1:0] copy_wdata_i,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o
);

    always_comb begin
        mem_read_o  = core_read_i;
        mem_write_o = core_write_i;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
        if (sel_i) begin
            mem_read_o  = copy_read_i;
            mem_write_o = copy_write_i;
            mem_addr_o  = copy_addr_i;
            mem_wdata_o = copy_wdata_i;
        end
    end

endmodule

// File: rtl/memcopy_sequencer.sv
// MEMCOPY sequencer: copies len words src->dst via one READ/WRITE pair per word,
// stalling the pipeline and owning the data-memory port while it runs.
module memcopy_sequencer
    import memcopy_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  core_mem_read,
    input  logic                  core_mem_write,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  stall,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);

    mc_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  copy_read_c;
    logic                  copy_write_c;
    logic [ADDR_WIDTH-1:0] copy_addr_c;

    // Next-state, pointer and counter update
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d   = src_addr & ALIGN_MASK;
                    dst_ptr_d   = dst_addr & ALIGN_MASK;
                    remaining_d = len;
                    state_d     = (len == '0) ? DONE : READ;
                end
            end
            READ:  state_d = WRITE;
            WRITE: begin
                src_ptr_d   = src_ptr_q + STRIDE;
                dst_ptr_d   = dst_ptr_q + STRIDE;
                remaining_d = remaining_q - LEN_ONE;
                state_d     = (remaining_q == LEN_ONE) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Copy-side port requests; read data is forwarded straight into the write
    always_comb begin
        copy_read_c  = (state_q == READ);
        copy_write_c = (state_q == WRITE);
        copy_addr_c  = copy_write_c ? dst_ptr_q : src_ptr_q;
    end

    mem_port_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_port_mux (
        .sel_i        (busy_q),
        .core_read_i  (core_mem_read),
        .core_write_i (core_mem_write),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .copy_read_i  (copy_read_c),
        .copy_write_i (copy_write_c),
        .copy_addr_i  (copy_addr_c),
        .copy_wdata_i (mem_rdata),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata)
    );

    // Stall must cover the issue cycle itself so the MEMCOPY instruction holds in EX
    assign stall = ((state_q == IDLE) && start) || busy_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
